// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, one outstanding imem request, single-entry IF/ID register.
// Optional: define RV32I_IF_PERF_CNT_EN to enable the delivered-instruction counter on fetch_count.
module rv32i_if_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [31:0]     fetch_count
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_kill, w_kill_next;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [31:0]     r_id_instr;

  logic w_req_valid;
  logic w_req_fire;
  logic w_id_fire;
  logic w_rsp_load;

  // A request may only go out when the IF/ID register is empty or draining this cycle.
  assign w_id_fire   = r_id_valid & id_ready;
  assign w_req_valid = (r_state == REQ) & en & (~r_id_valid | id_ready);
  assign w_req_fire  = w_req_valid & imem_req_ready;
  assign w_rsp_load  = (r_state == WAIT) & imem_rsp_valid & ~r_kill & ~redirect_valid;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_kill_next  = r_kill;
    if (redirect_valid) begin
      w_pc_next = redirect_pc & ~(XLEN'(3));
      // Kill only when a request is still in flight after this edge.
      if (((r_state == WAIT) && !imem_rsp_valid) || w_req_fire) begin
        w_kill_next  = 1'b1;
        w_state_next = WAIT;
      end else begin
        w_kill_next  = 1'b0;
        w_state_next = REQ;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (en) w_state_next = REQ;
        end
        REQ: begin
          if (w_req_fire)  w_state_next = WAIT;
          else if (!en)    w_state_next = IDLE;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            w_kill_next  = 1'b0;
            w_state_next = REQ;
            if (!r_kill) w_pc_next = r_pc + XLEN'(4);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_kill  <= w_kill_next;
    end
  end

  // IF/ID register: flush on redirect, load on a live response, otherwise drain on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
    end else if (w_rsp_load) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_pc;
      r_id_instr <= imem_rsp_data;
    end else if (w_id_fire) begin
      r_id_valid <= 1'b0;
    end
  end

`ifdef RV32I_IF_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_fetch_count <= '0;
    else if (w_id_fire) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = '0;
`endif

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = r_id_valid;
  assign id_pc          = r_id_pc;
  assign id_instr       = r_id_instr;

endmodule
